// File: rtl/pipeline_hazard_ctrl_if.sv
// Control/status bundle between the hazard sequencer and the 5-stage datapath.
// The master side is the sequencer: it observes hazard sources and drives the
// stage enables. The slave side is the datapath.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    // Hazard sources reported by the datapath
    logic [4:0]       ID_rs;
    logic [4:0]       ID_rt;
    logic             ID_uses_rs;
    logic             ID_uses_rt;
    logic             EX_mem_read;
    logic [4:0]       EX_rt;
    logic             ID_branch_taken;
    logic             MEM_mem_req;
    logic             dmem_ready;

    // Stage controls and status driven by the sequencer
    logic             PC_write_en;
    logic             IF_ID_write_en;
    logic             IF_flush;
    logic             ID_EX_write_en;
    logic             EX_MEM_write_en;
    logic             ID_EX_bubble;
    logic             MEM_WB_bubble;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        input  ID_rs, ID_rt, ID_uses_rs, ID_uses_rt, EX_mem_read, EX_rt,
               ID_branch_taken, MEM_mem_req, dmem_ready,
        output PC_write_en, IF_ID_write_en, IF_flush, ID_EX_write_en,
               EX_MEM_write_en, ID_EX_bubble, MEM_WB_bubble, mem_timeout,
               stall_cycles
    );

    modport slave (
        output ID_rs, ID_rt, ID_uses_rs, ID_uses_rt, EX_mem_read, EX_rt,
               ID_branch_taken, MEM_mem_req, dmem_ready,
        input  PC_write_en, IF_ID_write_en, IF_flush, ID_EX_write_en,
               EX_MEM_write_en, ID_EX_bubble, MEM_WB_bubble, mem_timeout,
               stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: post-reset boot hold,
// load-use stall, taken-branch flush, data-memory wait freeze with a sticky
// timeout flag, and a saturating count of stalled cycles.
module pipeline_hazard_ctrl #(
    parameter int BOOT_CYCLES = 4,
    parameter int MAX_WAIT    = 255,
    parameter int CNT_W       = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pipeline_hazard_ctrl_if.master      bus
);
    localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    state_t           state_q;
    logic [BW-1:0]    boot_cnt_q;
    logic [WW-1:0]    wait_cnt_q;
    logic             timeout_q;
    logic [CNT_W-1:0] stall_q;

    logic             freeze_s;
    logic             hazard_s;
    logic             pc_we_s;
    logic             ifid_we_s;
    logic             idex_we_s;
    logic             exmem_we_s;
    logic             idex_bub_s;
    logic             memwb_bub_s;
    logic             flush_s;
    logic             stall_inc_s;

    // Hazard detection: memory freeze and load-use dependency on a non-zero register
    always_comb begin
        freeze_s = bus.MEM_mem_req & ~bus.dmem_ready;
        hazard_s = bus.EX_mem_read & (bus.EX_rt != 5'd0) &
                   ((bus.ID_uses_rs & (bus.EX_rt == bus.ID_rs)) |
                    (bus.ID_uses_rt & (bus.EX_rt == bus.ID_rt)));
    end

    // Stage control decode: boot hold, then freeze > hazard > branch > normal
    always_comb begin
        pc_we_s     = 1'b0;
        ifid_we_s   = 1'b0;
        idex_we_s   = 1'b0;
        exmem_we_s  = 1'b0;
        idex_bub_s  = 1'b1;
        memwb_bub_s = 1'b1;
        flush_s     = 1'b0;
        stall_inc_s = 1'b0;
        case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
                if (freeze_s) begin
                    // Every upstream stage holds; only MEM/WB gets a NOP
                    idex_bub_s  = 1'b0;
                    memwb_bub_s = 1'b1;
                end else if (hazard_s) begin
                    idex_we_s   = 1'b1;
                    exmem_we_s  = 1'b1;
                    idex_bub_s  = 1'b1;
                    memwb_bub_s = 1'b0;
                end else begin
                    pc_we_s     = 1'b1;
                    ifid_we_s   = 1'b1;
                    idex_we_s   = 1'b1;
                    exmem_we_s  = 1'b1;
                    idex_bub_s  = 1'b0;
                    memwb_bub_s = 1'b0;
                    flush_s     = bus.ID_branch_taken;
                end
                stall_inc_s = ~pc_we_s;
            end
            default: begin
                // Boot hold keeps the defaults: everything frozen, bubbles loaded
                stall_inc_s = 1'b0;
            end
        endcase
    end

    // Sequencer state, boot/wait counters, sticky timeout and stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= BW'(BOOT_CYCLES - 1);
            wait_cnt_q <= {WW{1'b0}};
            timeout_q  <= 1'b0;
            stall_q    <= {CNT_W{1'b0}};
        end else begin
            if (stall_inc_s && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            case (state_q)
                ST_BOOT: begin
                    if (boot_cnt_q == {BW{1'b0}}) begin
                        state_q <= ST_RUN;
                    end else begin
                        boot_cnt_q <= boot_cnt_q - BW'(1);
                    end
                end
                ST_RUN: begin
                    if (freeze_s) begin
                        state_q    <= ST_MEM_WAIT;
                        wait_cnt_q <= {WW{1'b0}};
                    end
                end
                ST_MEM_WAIT: begin
                    if (freeze_s) begin
                        // No forced recovery: the flag is raised and the wait continues
                        if (wait_cnt_q == WW'(MAX_WAIT)) begin
                            timeout_q <= 1'b1;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + WW'(1);
                        end
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    state_q <= ST_BOOT;
                end
            endcase
        end
    end

    // Drive the bundle from the decode and the status registers
    always_comb begin
        bus.PC_write_en     = pc_we_s;
        bus.IF_ID_write_en  = ifid_we_s;
        bus.ID_EX_write_en  = idex_we_s;
        bus.EX_MEM_write_en = exmem_we_s;
        bus.ID_EX_bubble    = idex_bub_s;
        bus.MEM_WB_bubble   = memwb_bub_s;
        bus.IF_flush        = flush_s;
        bus.mem_timeout     = timeout_q;
        bus.stall_cycles    = stall_q;
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a cycle-level reference model.
module tb_pipeline_hazard_ctrl;
    localparam int BOOT  = 4;
    localparam int MAXW  = 5;
    localparam int CW    = 4;
    localparam int SATV  = (1 << CW) - 1;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus ();

    pipeline_hazard_ctrl #(
        .BOOT_CYCLES(BOOT),
        .MAX_WAIT   (MAXW),
        .CNT_W      (CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: boot cycles left, length of the current freeze
    // streak, sticky timeout, and saturating stall count.
    int m_boot   = BOOT;
    int m_streak = 0;
    bit m_to     = 1'b0;
    int m_stall  = 0;

    function automatic bit m_freeze();
        return bus.MEM_mem_req && !bus.dmem_ready;
    endfunction

    function automatic bit m_hazard();
        return bus.EX_mem_read && (bus.EX_rt != 5'd0) &&
               ((bus.ID_uses_rs && bus.EX_rt == bus.ID_rs) ||
                (bus.ID_uses_rt && bus.EX_rt == bus.ID_rt));
    endfunction

    // {PC_we, IFID_we, IDEX_we, EXMEM_we, IDEX_bubble, MEMWB_bubble, IF_flush}
    function automatic logic [6:0] m_ctrl();
        if (m_boot > 0)    return 7'b0000_110;
        if (m_freeze())    return 7'b0000_010;
        if (m_hazard())    return 7'b0011_100;
        if (bus.ID_branch_taken) return 7'b1111_001;
        return 7'b1111_000;
    endfunction

    // Advance the model once per clock
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_boot   <= BOOT;
            m_streak <= 0;
            m_to     <= 1'b0;
            m_stall  <= 0;
        end else if (m_boot > 0) begin
            m_boot <= m_boot - 1;
        end else begin
            // The streak's first cycle is in RUN; the wait counter only starts
            // counting from the second, so MAXW+1 earlier freeze cycles are needed.
            if (m_freeze() && m_streak >= MAXW + 1) m_to <= 1'b1;
            m_streak <= m_freeze() ? m_streak + 1 : 0;
            if (m_ctrl()[6] == 1'b0) m_stall <= (m_stall >= SATV) ? SATV : m_stall + 1;
        end
    end

    // Compare every cycle, well away from the rising edge
    always @(negedge clk) begin
        logic [6:0] act;
        logic [6:0] expv;
        #2;
        act  = {bus.PC_write_en, bus.IF_ID_write_en, bus.ID_EX_write_en,
                bus.EX_MEM_write_en, bus.ID_EX_bubble, bus.MEM_WB_bubble, bus.IF_flush};
        expv = m_ctrl();
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL ctrl @%0t: got %b expected %b", $time, act, expv);
        end
        checks++;
        if (bus.mem_timeout !== m_to) begin
            errors++;
            $display("FAIL mem_timeout @%0t: got %b expected %b", $time, bus.mem_timeout, m_to);
        end
        checks++;
        if (bus.stall_cycles !== CW'(m_stall)) begin
            errors++;
            $display("FAIL stall_cycles @%0t: got %0d expected %0d", $time, bus.stall_cycles, m_stall);
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic mr,
                         input logic [4:0] ert, input logic br,
                         input logic req, input logic rdy);
        @(negedge clk);
        bus.ID_rs           = rs;
        bus.ID_rt           = rt;
        bus.ID_uses_rs      = urs;
        bus.ID_uses_rt      = urt;
        bus.EX_mem_read     = mr;
        bus.EX_rt           = ert;
        bus.ID_branch_taken = br;
        bus.MEM_mem_req     = req;
        bus.dmem_ready      = rdy;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.ID_rs = 5'd0; bus.ID_rt = 5'd0; bus.ID_uses_rs = 1'b0; bus.ID_uses_rt = 1'b0;
        bus.EX_mem_read = 1'b0; bus.EX_rt = 5'd0; bus.ID_branch_taken = 1'b0;
        bus.MEM_mem_req = 1'b0; bus.dmem_ready = 1'b1;
        idle();
        idle();
        #3 lit("rst_pc", bus.PC_write_en, 0);
        lit("rst_memwb_bubble", bus.MEM_WB_bubble, 1);

        // Boot: the release window plus three more are held
        idle();
        rst_n = 1'b1;
        repeat (3) idle();
        #3 lit("boot4_pc", bus.PC_write_en, 0);
        lit("boot4_idex_bubble", bus.ID_EX_bubble, 1);
        idle();
        #3 lit("run_pc", bus.PC_write_en, 1);
        lit("run_stall", bus.stall_cycles, 0);

        // Load-use on rs
        drive(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1);
        #3 lit("lu_pc", bus.PC_write_en, 0);
        lit("lu_bubble", bus.ID_EX_bubble, 1);
        idle();
        #3 lit("lu_after_pc", bus.PC_write_en, 1);
        lit("lu_stall", bus.stall_cycles, 1);

        // Load to r0 is never a hazard
        drive(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        #3 lit("r0_pc", bus.PC_write_en, 1);

        // Branch alone, then branch during a load-use stall on rt
        drive(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
        #3 lit("br_flush", bus.IF_flush, 1);
        idle();
        #3 lit("br_after_flush", bus.IF_flush, 0);
        drive(5'd3, 5'd9, 1'b1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1);
        #3 lit("brhz_flush", bus.IF_flush, 0);
        lit("brhz_pc", bus.PC_write_en, 0);
        idle();

        // Three-cycle memory wait, zero-bubble release
        repeat (3) drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        #3 lit("mw_pc", bus.PC_write_en, 0);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        #3 lit("mw_release_pc", bus.PC_write_en, 1);
        lit("mw_stall", bus.stall_cycles, 5);

        // Freeze outranks hazard and branch
        drive(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0);
        #3 lit("fp_idex_bubble", bus.ID_EX_bubble, 0);
        lit("fp_flush", bus.IF_flush, 0);
        lit("fp_memwb_bubble", bus.MEM_WB_bubble, 1);
        idle();

        // Eight-cycle wait with MAX_WAIT = 5 raises the sticky timeout
        repeat (8) drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        #3 lit("to_set", bus.mem_timeout, 1);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        #3 lit("to_sticky", bus.mem_timeout, 1);
        lit("to_stall", bus.stall_cycles, 14);

        // Stall counter saturates at all-ones
        repeat (3) drive(5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1);
        idle();
        #3 lit("sat_stall", bus.stall_cycles, SATV);

        // Asynchronous reset in the middle of a memory wait
        repeat (2) drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        #4 rst_n = 1'b0;
        #1 lit("arst_pc", bus.PC_write_en, 0);
        lit("arst_idex_bubble", bus.ID_EX_bubble, 1);
        lit("arst_timeout", bus.mem_timeout, 0);
        lit("arst_stall", bus.stall_cycles, 0);
        idle();
        idle();
        rst_n = 1'b1;
        repeat (6) idle();
        #3 lit("reboot_pc", bus.PC_write_en, 1);
        @(negedge clk);
        #4;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
